// File: rtl/boss_attack_scheduler_pkg.sv
// Shared constants for the boss attack scheduler: state encoding, slot geometry,
// attack types and HP width.
package boss_pkg;

  localparam int NUM_SLOTS = 5;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);
  localparam int HP_W      = 10;

  localparam logic ATTACK_SINGLE = 1'b0;
  localparam logic ATTACK_BURST  = 1'b1;

  localparam logic [2:0] ST_COOLDOWN = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_SPAWN    = 3'd2;
  localparam logic [2:0] ST_STAGGER  = 3'd3;
  localparam logic [2:0] ST_HALT     = 3'd4;

endpackage

// File: rtl/boss_attack_scheduler_if.sv
// Game-side bundle between the boss scheduler (master) and the tick source,
// boss datapath and projectile datapath (slave).
interface boss_attack_scheduler_if
  import boss_pkg::*;
#(
  parameter int DELAY_W = 32
);
  logic                 pulse_cycleStep;
  logic [DELAY_W-1:0]   delay;
  logic                 bossHit;
  logic [HP_W-1:0]      bossHP;
  logic [NUM_SLOTS-1:0] slotBusy;
  logic                 spawnAck;
  logic                 spawnReq;
  logic [SLOT_W-1:0]    spawnSlot;
  logic                 attackType;
  logic                 bossShoot;
  logic                 indicate1;
  logic                 indicate2;

  modport master (
    input  pulse_cycleStep, delay, bossHit, bossHP, slotBusy, spawnAck,
    output spawnReq, spawnSlot, attackType, bossShoot, indicate1, indicate2
  );

  modport slave (
    output pulse_cycleStep, delay, bossHit, bossHP, slotBusy, spawnAck,
    input  spawnReq, spawnSlot, attackType, bossShoot, indicate1, indicate2
  );
endinterface

// File: rtl/boss_attack_scheduler_rr_slot_picker.sv
// Combinational round-robin picker: first free slot at or after rr_ptr,
// wrapping modulo N.
module rr_slot_picker
  import boss_pkg::*;
#(
  parameter int N = NUM_SLOTS,
  parameter int W = SLOT_W
) (
  input  logic [N-1:0] slotBusy,
  input  logic [W-1:0] rr_ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int          w_sum;
  logic [W-1:0] w_cand;

  // Scan offsets high-to-low so the smallest offset from rr_ptr wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_sum  = 0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = int'(rr_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_cand = W'(w_sum);
      if (!slotBusy[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/boss_attack_scheduler.sv
// Boss attack FSM: cooldown timing, round-robin slot allocation, spawn handshake,
// hit stagger and death halt.
module boss_attack_scheduler
  import boss_pkg::*;
#(
  parameter int DELAY_W       = 32,
  parameter int BURST_LEN     = 3,
  parameter int STAGGER_TICKS = 8
) (
  input  logic               clk_master,
  input  logic               rst,
  boss_attack_scheduler_if.master bus
);

  localparam int SHOT_W = $clog2(BURST_LEN + 1);

  logic [2:0]         r_state;
  logic [DELAY_W-1:0] r_count;
  logic [SLOT_W-1:0]  r_rr_ptr;
  logic [SLOT_W-1:0]  r_spawn_slot;
  logic [SHOT_W-1:0]  r_shots;
  logic               r_hit_pending;
  logic               r_dead_pending;
  logic               r_spawn_req;
  logic               r_attack_type;
  logic               r_boss_shoot;

  logic               w_found;
  logic [SLOT_W-1:0]  w_idx;
  logic [DELAY_W:0]   w_count_inc;
  logic [DELAY_W:0]   w_delay_eff;
  logic               w_cool_done;
  logic               w_stag_done;
  logic               w_dead;
  logic [SLOT_W-1:0]  w_next_ptr;

  rr_slot_picker #(.N(NUM_SLOTS), .W(SLOT_W)) u_picker (
    .slotBusy (bus.slotBusy),
    .rr_ptr   (r_rr_ptr),
    .found    (w_found),
    .idx      (w_idx)
  );

  // One extra bit so count+1 never wraps against a full-scale delay.
  assign w_count_inc = {1'b0, r_count} + 1'b1;
  assign w_delay_eff = (bus.delay == '0) ? (DELAY_W+1)'(1) : {1'b0, bus.delay};
  assign w_cool_done = (w_count_inc >= w_delay_eff);
  assign w_stag_done = (w_count_inc >= (DELAY_W+1)'(STAGGER_TICKS));
  assign w_dead      = (bus.bossHP == '0);
  assign w_next_ptr  = (r_spawn_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_spawn_slot + 1'b1;

  always_ff @(posedge clk_master or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_COOLDOWN;
      r_count        <= '0;
      r_rr_ptr       <= '0;
      r_spawn_slot   <= '0;
      r_shots        <= '0;
      r_hit_pending  <= 1'b0;
      r_dead_pending <= 1'b0;
      r_spawn_req    <= 1'b0;
      r_attack_type  <= ATTACK_SINGLE;
      r_boss_shoot   <= 1'b0;
    end else begin
      r_boss_shoot <= 1'b0;
      case (r_state)
        ST_COOLDOWN: begin
          if (w_dead) begin
            r_state <= ST_HALT;
          end else if (bus.bossHit) begin
            r_state <= ST_STAGGER;
            r_count <= '0;
          end else if (bus.pulse_cycleStep) begin
            if (w_cool_done) begin
              r_count <= '0;
              r_state <= ST_SELECT;
              r_shots <= (r_attack_type == ATTACK_BURST) ? SHOT_W'(BURST_LEN) : SHOT_W'(1);
            end else begin
              r_count <= w_count_inc[DELAY_W-1:0];
            end
          end
        end
        ST_SELECT: begin
          if (w_dead) begin
            r_state <= ST_HALT;
          end else begin
            if (bus.bossHit) r_hit_pending <= 1'b1;
            if (w_found) begin
              r_spawn_slot <= w_idx;
              r_spawn_req  <= 1'b1;
              r_state      <= ST_SPAWN;
            end
          end
        end
        ST_SPAWN: begin
          if (w_dead) r_dead_pending <= 1'b1;
          if (bus.bossHit) r_hit_pending <= 1'b1;
          if (bus.spawnAck) begin
            r_spawn_req  <= 1'b0;
            r_boss_shoot <= 1'b1;
            r_rr_ptr     <= w_next_ptr;
            r_shots      <= r_shots - 1'b1;
            if (r_shots == SHOT_W'(1)) r_attack_type <= ~r_attack_type;
            // Death seen at any point of the handshake wins once it completes.
            if (w_dead || r_dead_pending) begin
              r_state <= ST_HALT;
            end else if (r_shots == SHOT_W'(1)) begin
              r_count <= '0;
              r_state <= (r_hit_pending || bus.bossHit) ? ST_STAGGER : ST_COOLDOWN;
            end else begin
              r_state <= ST_SELECT;
            end
          end
        end
        ST_STAGGER: begin
          if (w_dead) begin
            r_state <= ST_HALT;
          end else if (bus.bossHit) begin
            r_count <= '0;
          end else if (bus.pulse_cycleStep) begin
            if (w_stag_done) begin
              r_count       <= '0;
              r_hit_pending <= 1'b0;
              r_state       <= ST_COOLDOWN;
            end else begin
              r_count <= w_count_inc[DELAY_W-1:0];
            end
          end
        end
        ST_HALT: begin
          r_spawn_req <= 1'b0;
        end
        default: begin
          r_state <= ST_COOLDOWN;
        end
      endcase
    end
  end

  assign bus.spawnReq   = r_spawn_req;
  assign bus.spawnSlot  = r_spawn_slot;
  assign bus.attackType = r_attack_type;
  assign bus.bossShoot  = r_boss_shoot;
  assign bus.indicate1  = (r_state == ST_STAGGER);
  assign bus.indicate2  = (r_state == ST_HALT);

endmodule
